sdram_delay_calibrator: RTL and testbench
=========================================

SDRAM_DELAY_CALIBRATOR -- requirements
Module: sdram_delay_calibrator

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8, idle cycles after each tap change before testing (1..255).
REQ-002 Parameter SAMPLES, default 4, test reads per tap; a tap passes only if all pass (1..15).
REQ-003 Parameter DEFAULT_TAP, default 4'd0, tap driven out of reset and after a failed calibration.
REQ-004 sdram_clk  input  1  single clock; all state updates on the rising edge.
REQ-005 sdram_resetn  input  1  asynchronous, active-low reset.
REQ-006 cal_start  input  1  one-cycle pulse that begins a calibration sweep.
REQ-007 test_req  output  1  request for one test read at the current tap.
REQ-008 test_ack  input  1  test read complete; qualifies test_pass.
REQ-009 test_pass  input  1  test read data matched expected pattern; valid only with test_ack.
REQ-010 delay_config_reg  output  4  tap select for the programmable delay cell (bit3 invert, bits2:0 chain select).
REQ-011 cal_busy  output  1  high from the cycle after accepted cal_start until DONE/FAIL is entered.
REQ-012 cal_done  output  1  one-cycle pulse: calibration succeeded.
REQ-013 cal_fail  output  1  one-cycle pulse: no passing tap found.
REQ-014 win_len  output  5  length of best passing window from the last sweep (0..16).

Function
REQ-015 FSM states IDLE, APPLY, SETTLE, TEST, EVAL, FINISH; IDLE after reset.
REQ-016 IDLE: cal_start=1 -> tap counter=0, window registers cleared, go APPLY; cal_start ignored in all other states.
REQ-017 APPLY: drive delay_config_reg=tap counter, load settle counter=SETTLE_CYCLES, go SETTLE (1 cycle).
REQ-018 SETTLE: decrement each cycle; on reaching 0 go TEST with sample counter=0 and pass flag=1.
REQ-019 TEST: test_req high and held until a cycle with test_ack=1; in that cycle pass flag &= test_pass, sample counter++, test_req low the following cycle.
REQ-020 test_req re-asserts one cycle after each ack until SAMPLES acks are taken, then go EVAL; test_ack while test_req=0 is ignored.
REQ-021 EVAL (1 cycle): pass -> cur_len++ (cur_start=tap if cur_len was 0); fail -> cur_len=0; best window updated only if new cur_len strictly greater than best_len (earliest window wins ties).
REQ-022 EVAL: tap<15 -> tap++, go APPLY; tap=15 -> go FINISH; no wrap-around between tap 15 and tap 0.
REQ-023 Window arithmetic uses 5-bit lengths; run of all 16 taps gives best_len=16 without overflow.
REQ-024 FINISH (1 cycle): best_len>0 -> delay_config_reg=best_start+((best_len-1)>>1), pulse cal_done; best_len=0 -> delay_config_reg=DEFAULT_TAP, pulse cal_fail; win_len=best_len; go IDLE.
REQ-025 delay_config_reg is registered and changes only in APPLY, FINISH, or reset; glitch-free for the delay cell.
REQ-026 Latency per tap = 1 (APPLY) + SETTLE_CYCLES + test time + 1 (EVAL); full sweep with zero-wait acks is deterministic.
REQ-027 cal_done and cal_fail are mutually exclusive and never asserted with cal_busy.

Reset
REQ-028 sdram_resetn low asynchronously forces: state IDLE, delay_config_reg=DEFAULT_TAP, test_req=0, cal_busy=0, cal_done=0, cal_fail=0, win_len=0, all counters/window registers 0.
REQ-029 Reset mid-sweep abandons the sweep with no done/fail pulse; release returns to IDLE awaiting cal_start.
REQ-030 Reset deassertion is synchronized externally; block takes no action in the release cycle beyond IDLE.

Structure
REQ-031 Shared package holds the FSM state encoding, NUM_TAPS=16, and tap-width constant (4).
REQ-032 One sub-module, sdram_cal_window_tracker, holds cur/best start/len and the strict-greater update; FSM and handshake stay in the top.
REQ-033 Block drives the existing programmable delay cell's 4-bit config input directly; no combinational path from test inputs to delay_config_reg.

Verification
REQ-034 Reset with DEFAULT_TAP=4'd5 -> delay_config_reg=5, all strobes 0; cal_start -> APPLY, tap 0 driven.
REQ-035 Pass map taps 3..9 only, SAMPLES=4, immediate acks -> cal_done, delay_config_reg=6, win_len=7.
REQ-036 Pass map taps 1..3 and 10..12 (tie) -> delay_config_reg=2, win_len=3; all 16 pass -> delay_config_reg=7, win_len=16.
REQ-037 Tap 4 with 3 passes then 1 fail, taps 0..3 and 5..6 pass -> tap 4 rejected, result 1, win_len=4.
REQ-038 No tap passes -> cal_fail pulse, delay_config_reg=DEFAULT_TAP, win_len=0; cal_start during busy ignored.
REQ-039 sdram_resetn low during TEST at tap 8 with test_req high -> test_req=0 immediately, no done/fail, IDLE after release.

Source files
------------

// File: rtl/sdram_delay_calibrator_pkg.sv
// Shared constants, FSM encoding and window-centre helper for the delay calibrator.
package sdram_delay_calibrator_pkg;

  localparam int unsigned NUM_TAPS = 16;
  localparam int unsigned TAP_W    = 4;
  localparam int unsigned LEN_W    = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_TEST   = 3'd3,
    S_EVAL   = 3'd4,
    S_FINISH = 3'd5
  } cal_state_e;

  // Middle tap of a window; even-length windows round toward the lower tap.
  function automatic logic [TAP_W-1:0] center_tap(input logic [TAP_W-1:0] start,
                                                  input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] half;
    half = (len - LEN_W'(1)) >> 1;
    return start + TAP_W'(half);
  endfunction

endpackage

// File: rtl/sdram_cal_window_tracker.sv
// Tracks the current run of passing taps and the longest (earliest on ties) run seen.
module sdram_cal_window_tracker
  import sdram_delay_calibrator_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_eval,
  input  logic             i_pass,
  input  logic [TAP_W-1:0] i_tap,
  output logic [TAP_W-1:0] o_best_start,
  output logic [LEN_W-1:0] o_best_len
);

  logic [TAP_W-1:0] r_cur_start;
  logic [LEN_W-1:0] r_cur_len;
  logic [TAP_W-1:0] r_best_start;
  logic [LEN_W-1:0] r_best_len;

  logic [LEN_W-1:0] w_run_len;
  logic [TAP_W-1:0] w_run_start;

  // Run extended by the tap being evaluated; a new run starts at that tap.
  always_comb begin
    w_run_len   = r_cur_len + LEN_W'(1);
    w_run_start = (r_cur_len == '0) ? i_tap : r_cur_start;
  end

  // Window registers; best only replaced by a strictly longer run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (i_clear) begin
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (i_eval) begin
      if (i_pass) begin
        r_cur_len   <= w_run_len;
        r_cur_start <= w_run_start;
        if (w_run_len > r_best_len) begin
          r_best_len   <= w_run_len;
          r_best_start <= w_run_start;
        end
      end else begin
        r_cur_len <= '0;
      end
    end
  end

  assign o_best_start = r_best_start;
  assign o_best_len   = r_best_len;

endmodule

// File: rtl/sdram_delay_calibrator.sv
// Sweeps all delay taps, tests each with SAMPLES reads, and centres on the best passing window.
module sdram_delay_calibrator
  import sdram_delay_calibrator_pkg::*;
#(
  parameter int unsigned      SETTLE_CYCLES = 8,
  parameter int unsigned      SAMPLES       = 4,
  parameter logic [TAP_W-1:0] DEFAULT_TAP   = 4'd0
) (
  input  logic             sdram_clk,
  input  logic             sdram_resetn,
  input  logic             cal_start,
  output logic             test_req,
  input  logic             test_ack,
  input  logic             test_pass,
  output logic [TAP_W-1:0] delay_config_reg,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [LEN_W-1:0] win_len
);

  localparam int unsigned SETTLE_W = 8;
  localparam int unsigned SAMPLE_W = 4;

  cal_state_e          r_state,    w_state_nxt;
  logic [TAP_W-1:0]    r_tap,      w_tap_nxt;
  logic [SETTLE_W-1:0] r_settle,   w_settle_nxt;
  logic [SAMPLE_W-1:0] r_sample,   w_sample_nxt;
  logic                r_pass,     w_pass_nxt;
  logic                r_test_req, w_test_req_nxt;
  logic [TAP_W-1:0]    r_cfg,      w_cfg_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_fail,     w_fail_nxt;
  logic [LEN_W-1:0]    r_win_len,  w_win_len_nxt;

  logic                w_clear;
  logic                w_eval;
  logic [TAP_W-1:0]    w_best_start;
  logic [LEN_W-1:0]    w_best_len;

  sdram_cal_window_tracker u_window (
    .clk          (sdram_clk),
    .rst_n        (sdram_resetn),
    .i_clear      (w_clear),
    .i_eval       (w_eval),
    .i_pass       (r_pass),
    .i_tap        (r_tap),
    .o_best_start (w_best_start),
    .o_best_len   (w_best_len)
  );

  // State and registered-output update.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_state    <= S_IDLE;
      r_tap      <= '0;
      r_settle   <= '0;
      r_sample   <= '0;
      r_pass     <= 1'b0;
      r_test_req <= 1'b0;
      r_cfg      <= DEFAULT_TAP;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_win_len  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tap      <= w_tap_nxt;
      r_settle   <= w_settle_nxt;
      r_sample   <= w_sample_nxt;
      r_pass     <= w_pass_nxt;
      r_test_req <= w_test_req_nxt;
      r_cfg      <= w_cfg_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_fail     <= w_fail_nxt;
      r_win_len  <= w_win_len_nxt;
    end
  end

  // Next-state and next-output logic for the sweep.
  always_comb begin
    w_state_nxt    = r_state;
    w_tap_nxt      = r_tap;
    w_settle_nxt   = r_settle;
    w_sample_nxt   = r_sample;
    w_pass_nxt     = r_pass;
    w_test_req_nxt = r_test_req;
    w_cfg_nxt      = r_cfg;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_fail_nxt     = 1'b0;
    w_win_len_nxt  = r_win_len;
    w_clear        = 1'b0;
    w_eval         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cal_start) begin
          w_tap_nxt   = '0;
          w_clear     = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_APPLY;
        end
      end

      S_APPLY: begin
        w_cfg_nxt    = r_tap;
        w_settle_nxt = SETTLE_W'(SETTLE_CYCLES);
        w_state_nxt  = S_SETTLE;
      end

      S_SETTLE: begin
        w_settle_nxt = r_settle - SETTLE_W'(1);
        if (r_settle <= SETTLE_W'(1)) begin
          w_sample_nxt   = '0;
          w_pass_nxt     = 1'b1;
          w_test_req_nxt = 1'b1;
          w_state_nxt    = S_TEST;
        end
      end

      S_TEST: begin
        if (r_test_req) begin
          if (test_ack) begin
            w_pass_nxt     = r_pass & test_pass;
            w_sample_nxt   = r_sample + SAMPLE_W'(1);
            w_test_req_nxt = 1'b0;
            if (r_sample == SAMPLE_W'(SAMPLES - 1)) begin
              w_state_nxt = S_EVAL;
            end
          end
        end else begin
          // One idle cycle after each ack, then request the next sample.
          w_test_req_nxt = 1'b1;
        end
      end

      S_EVAL: begin
        w_eval = 1'b1;
        if (r_tap == TAP_W'(NUM_TAPS - 1)) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_tap_nxt   = r_tap + TAP_W'(1);
          w_state_nxt = S_APPLY;
        end
      end

      S_FINISH: begin
        w_busy_nxt    = 1'b0;
        w_win_len_nxt = w_best_len;
        if (w_best_len != '0) begin
          w_cfg_nxt  = center_tap(w_best_start, w_best_len);
          w_done_nxt = 1'b1;
        end else begin
          w_cfg_nxt  = DEFAULT_TAP;
          w_fail_nxt = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign test_req         = r_test_req;
  assign delay_config_reg = r_cfg;
  assign cal_busy         = r_busy;
  assign cal_done         = r_done;
  assign cal_fail         = r_fail;
  assign win_len          = r_win_len;

endmodule

// File: tb/tb_sdram_delay_calibrator.sv
// Scoreboard bench: stimulus pushes expected sweep results, a monitor pops and compares.
module tb_sdram_delay_calibrator;

  localparam int unsigned NT      = 16;
  localparam int unsigned NS      = 4;
  localparam int unsigned SETTLE  = 3;
  localparam logic [3:0]  DEF_TAP = 4'd5;

  logic       sdram_clk;
  logic       sdram_resetn;
  logic       cal_start;
  logic       test_req;
  logic       test_ack;
  logic       test_pass;
  logic [3:0] delay_config_reg;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;
  logic [4:0] win_len;

  sdram_delay_calibrator #(
    .SETTLE_CYCLES (SETTLE),
    .SAMPLES       (NS),
    .DEFAULT_TAP   (DEF_TAP)
  ) dut (
    .sdram_clk        (sdram_clk),
    .sdram_resetn     (sdram_resetn),
    .cal_start        (cal_start),
    .test_req         (test_req),
    .test_ack         (test_ack),
    .test_pass        (test_pass),
    .delay_config_reg (delay_config_reg),
    .cal_busy         (cal_busy),
    .cal_done         (cal_done),
    .cal_fail         (cal_fail),
    .win_len          (win_len)
  );

  initial sdram_clk = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  typedef struct {
    bit fail;
    int cfg;
    int len;
  } exp_t;

  typedef struct {
    int exp_tap;
    int act_cfg;
  } tapobs_t;

  exp_t    exp_q[$];
  tapobs_t tap_q[$];
  bit      pmap [NT][NS];
  int      ack_idx;
  int      timeouts;
  bit      stim_done;
  int      n_checks;
  int      n_errors;

  // Reference: longest all-pass tap range, earliest start among equals.
  function automatic exp_t model_result();
    exp_t r;
    bit   ok;
    r.fail = 1'b1;
    r.cfg  = int'(DEF_TAP);
    r.len  = 0;
    for (int len = NT; len >= 1; len--) begin
      for (int st = 0; st + len <= NT; st++) begin
        ok = 1'b1;
        for (int t = st; t < st + len; t++)
          for (int s = 0; s < NS; s++)
            if (!pmap[t][s]) ok = 1'b0;
        if (ok) begin
          r.fail = 1'b0;
          r.cfg  = st + (len - 1) / 2;
          r.len  = len;
          return r;
        end
      end
    end
    return r;
  endfunction

  function automatic void set_mask(input bit [15:0] m);
    for (int t = 0; t < NT; t++)
      for (int s = 0; s < NS; s++)
        pmap[t][s] = m[t];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_sweep(input bit poke_busy);
    bit seen;
    @(negedge sdram_clk);
    cal_start = 1'b1;
    exp_q.push_back(model_result());
    @(negedge sdram_clk);
    cal_start = 1'b0;
    if (poke_busy) begin
      repeat (40) @(negedge sdram_clk);
      cal_start = 1'b1;
      @(negedge sdram_clk);
      cal_start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge sdram_clk);
      if (cal_done || cal_fail) seen = 1'b1;
    end
    if (!seen) timeouts++;
    @(negedge sdram_clk);
  endtask

  task automatic reset_mid_sweep();
    bit hit;
    set_mask(16'hFFFF);
    @(negedge sdram_clk);
    cal_start = 1'b1;
    @(negedge sdram_clk);
    cal_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge sdram_clk);
      if (test_req && (ack_idx / NS) == 8) hit = 1'b1;
    end
    if (!hit) timeouts++;
    #1 sdram_resetn = 1'b0;
    repeat (3) @(negedge sdram_clk);
    #1 sdram_resetn = 1'b1;
    repeat (30) @(negedge sdram_clk);
  endtask

  // Test-read responder: random ack latency, pass/fail from the map, spurious acks while idle.
  initial begin
    int wait_cnt;
    int t;
    int s;
    ack_idx   = 0;
    wait_cnt  = 0;
    test_ack  = 1'b0;
    test_pass = 1'b0;
    forever begin
      @(negedge sdram_clk);
      if (!cal_busy) ack_idx = 0;
      test_ack  = 1'b0;
      test_pass = 1'b0;
      if (test_req) begin
        if (wait_cnt == 0) begin
          t = ack_idx / NS;
          s = ack_idx % NS;
          test_ack  = 1'b1;
          test_pass = (t < NT) ? pmap[t][s] : 1'b0;
          tap_q.push_back('{exp_tap: t, act_cfg: int'(delay_config_reg)});
          ack_idx++;
          wait_cnt = int'($urandom_range(0, 2));
        end else begin
          wait_cnt--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        test_ack  = 1'b1;
        test_pass = 1'b0;
      end
    end
  end

  // Stimulus sequence.
  initial begin
    bit [15:0] m;
    sdram_resetn = 1'b0;
    cal_start    = 1'b0;
    stim_done    = 1'b0;
    timeouts     = 0;
    set_mask(16'h0000);
    repeat (3) @(negedge sdram_clk);
    sdram_resetn = 1'b1;
    repeat (2) @(negedge sdram_clk);

    set_mask(16'h03F8);            // taps 3..9
    run_sweep(1'b0);
    set_mask(16'h1C0E);            // taps 1..3 and 10..12
    run_sweep(1'b0);
    set_mask(16'hFFFF);            // every tap
    run_sweep(1'b0);
    set_mask(16'h007F);            // taps 0..6, tap 4 fails its last sample
    pmap[4][3] = 1'b0;
    run_sweep(1'b0);
    set_mask(16'h0000);            // nothing passes, extra start while busy
    run_sweep(1'b1);

    reset_mid_sweep();

    for (int k = 0; k < 6; k++) begin
      m = 16'($urandom);
      set_mask(m);
      for (int t = 0; t < NT; t++)
        for (int s = 0; s < NS; s++)
          if (pmap[t][s] && $urandom_range(0, 15) == 0) pmap[t][s] = 1'b0;
      run_sweep(k == 2);
    end

    repeat (5) @(negedge sdram_clk);
    stim_done = 1'b1;
  end

  // Monitor: reset values, result pulses against the scoreboard, tap driven at each ack.
  initial begin
    exp_t    e;
    tapobs_t o;
    n_checks = 0;
    n_errors = 0;
    while (!stim_done) begin
      @(negedge sdram_clk);
      if (!sdram_resetn) begin
        chk("rst_cfg",      int'(delay_config_reg), int'(DEF_TAP));
        chk("rst_test_req", int'(test_req), 0);
        chk("rst_busy",     int'(cal_busy), 0);
        chk("rst_done",     int'(cal_done), 0);
        chk("rst_fail",     int'(cal_fail), 0);
        chk("rst_win_len",  int'(win_len), 0);
      end
      if (cal_done || cal_fail) begin
        chk("done_fail_excl", int'(cal_done && cal_fail), 0);
        chk("busy_at_result", int'(cal_busy), 0);
        if (exp_q.size() == 0) begin
          chk("result_expected", int'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          chk("result_fail", int'(cal_fail), int'(e.fail));
          chk("result_cfg",  int'(delay_config_reg), e.cfg);
          chk("result_len",  int'(win_len), e.len);
        end
      end
      while (tap_q.size() > 0) begin
        o = tap_q.pop_front();
        chk("sweep_tap", o.act_cfg, o.exp_tap);
      end
    end
    while (tap_q.size() > 0) begin
      o = tap_q.pop_front();
      chk("sweep_tap", o.act_cfg, o.exp_tap);
    end
    chk("results_pending", int'(exp_q.size()), 0);
    chk("timeouts", timeouts, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
